mem_stage_ext: RTL and testbench
================================

# mem_stage_ext

Parametrised memory stage for the 5-stage pipeline: the EX/MEM pipeline register plus a byte-addressable data memory.
- Supports byte/half/word loads and stores with sign or zero extension, a configurable memory latency with a stall handshake back to EX, and misalignment detection.
- Sits between the execute stage and write-back, and forwards the instruction tag (type/number) for the debug display.

## Interface
Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ADDR_W, 8, byte-address bits used; memory holds 2^ADDR_W bytes.
- LAT, 0, extra wait cycles per memory access; range 0..7.
- TAG_W, 4, width of the instruction type/number tags.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_destR  in  5  destination register.
- ex_inB  in  DATA_W  store data.
- ex_aluR  in  DATA_W  ALU result, also the effective byte address.
- ex_wreg  in  1  register write enable.
- ex_m2reg  in  1  load (write-back selects memory data).
- ex_wmem  in  1  store.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
- ex_unsigned  in  1  zero-extend loads.
- EXE_ins_type / EXE_ins_number  in  TAG_W  debug tags.
- mem_stall  out  1  EX must hold all inputs stable this cycle.
- mem_valid, mem_wreg, mem_m2reg  out  1  registered controls.
- mem_mdata  out  DATA_W  registered, extended load data.
- mem_aluR  out  DATA_W  registered ALU result.
- mem_destR  out  5  registered destination register.
- mem_misalign  out  1  registered misaligned-access flag.
- MEM_ins_type / MEM_ins_number  out  TAG_W  registered debug tags.

## Operation
- Memory op = ex_valid & (ex_m2reg | ex_wmem). Any other valid instruction passes through in 1 cycle with mem_mdata = 0.
- Misaligned access:
  - half with addr[0]=1, or word with addr[1:0]≠0.
  - No memory write, no stall, no wait states.
  - Outputs: mem_misalign=1, mem_wreg=0; all other fields pass through.
- Address: addr[ADDR_W-1:2] selects the word, addr[1:0] selects the lane. Upper address bits are ignored, so accesses wrap around.
- Stores:
  - byte: ex_inB[7:0] written to lane addr[1:0].
  - half: ex_inB[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - word: all 4 lanes written.
  - Little-endian. The write commits on the completing edge only.
- Loads: the selected byte/half is sign-extended, or zero-extended when ex_unsigned=1; a word load is returned unchanged. The read is combinational from the array and registered into mem_mdata.
- If ex_m2reg and ex_wmem are both set: the store is performed and mem_mdata returns the pre-store contents (read-before-write).
- ex_valid=0 loads a bubble: mem_valid, mem_wreg, mem_m2reg and mem_misalign are all 0.
- FSM, states IDLE and WAIT, with a 3-bit counter cnt:
  - IDLE, aligned memory op, LAT>0: mem_stall=1, go to WAIT with cnt=1, and load a bubble into the output registers.
  - WAIT: mem_stall = (cnt<LAT); cnt increments each cycle. When cnt==LAT: commit the write, load the output registers with the instruction, return to IDLE.
  - LAT=0: the FSM never leaves IDLE.
- Reset: every output register is 0, the FSM is in IDLE, cnt=0. Memory contents are not reset.

## Timing
- Non-memory op, misaligned op, or LAT=0: outputs valid 1 cycle after the edge that sampled the inputs.
- Memory op with LAT>0:
  - mem_stall is high for cycles 0..LAT-1, asserted combinationally in cycle 0.
  - Results appear on the outputs after the edge at the end of cycle LAT.
  - Exactly LAT bubbles are emitted to write-back.
- EX inputs are sampled only at the completing edge; they may not change while mem_stall=1.
- Back-to-back memory ops: the second is accepted in the cycle after the first completes.
- rst_n low mid-WAIT aborts the access: no write, and the outputs clear immediately.

## Structure
- Package mem_stage_pkg holds:
  - size constants SZ_B, SZ_H, SZ_W;
  - the state enum {IDLE, WAIT};
  - a function for lane enables and one for load extension.
- Sub-module data_mem_be contains the 2^(ADDR_W-2) × 32 array, with a 4-bit byte-enable write port and an asynchronous read port.

## Test plan
- LAT=0: sw 0xDEADBEEF @0x10, then lb @0x13 → mem_mdata=0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x10 → 0xFFFFBEEF.
- LAT=0: sb 0x12345678 @0x21 onto a zeroed word; lw @0x20 → 0x00007800.
- LAT=3: lw → mem_stall high for exactly 3 cycles, then a 1-cycle pulse with mem_valid=1, mem_m2reg=1 and correct data; mem_valid=0 during the stall.
- sh @0x11 → mem_misalign=1, mem_wreg=0, no stall, memory unchanged on lw @0x10.
- LAT=3: rst_n low in the second WAIT cycle of sw @0x30 → all outputs 0 and the word @0x30 unchanged.
- ADDR_W=8: sw @0x104 followed by lw @0x004 → same data (wrap-around).

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and lane/extension helpers for the memory stage.
// Assumes a 32-bit datapath split into four little-endian byte lanes.
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the datum across lanes lets the byte enables pick the target lane.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ext_if.sv
// EX-to-MEM bus: EX-side inputs, the stall back to EX, and the registered MEM outputs.
interface mem_stage_ext_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              ex_valid;
  logic [4:0]        ex_destR;
  logic [DATA_W-1:0] ex_inB;
  logic [DATA_W-1:0] ex_aluR;
  logic              ex_wreg;
  logic              ex_m2reg;
  logic              ex_wmem;
  logic [1:0]        ex_size;
  logic              ex_unsigned;
  logic [TAG_W-1:0]  EXE_ins_type;
  logic [TAG_W-1:0]  EXE_ins_number;

  logic              mem_stall;
  logic              mem_valid;
  logic              mem_wreg;
  logic              mem_m2reg;
  logic [DATA_W-1:0] mem_mdata;
  logic [DATA_W-1:0] mem_aluR;
  logic [4:0]        mem_destR;
  logic              mem_misalign;
  logic [TAG_W-1:0]  MEM_ins_type;
  logic [TAG_W-1:0]  MEM_ins_number;

  modport master (
    output ex_valid, ex_destR, ex_inB, ex_aluR, ex_wreg, ex_m2reg, ex_wmem,
           ex_size, ex_unsigned, EXE_ins_type, EXE_ins_number,
    input  mem_stall, mem_valid, mem_wreg, mem_m2reg, mem_mdata, mem_aluR,
           mem_destR, mem_misalign, MEM_ins_type, MEM_ins_number
  );

  modport slave (
    input  ex_valid, ex_destR, ex_inB, ex_aluR, ex_wreg, ex_m2reg, ex_wmem,
           ex_size, ex_unsigned, EXE_ins_type, EXE_ins_number,
    output mem_stall, mem_valid, mem_wreg, mem_m2reg, mem_mdata, mem_aluR,
           mem_destR, mem_misalign, MEM_ins_type, MEM_ins_number
  );
endinterface

// File: rtl/data_mem_be.sv
// Word-organised data RAM: byte-enable synchronous write, asynchronous read, same address.
// Contents are deliberately not reset.
module data_mem_be #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_ext.sv
// EX/MEM register plus data memory; aligned loads/stores stall EX for LAT wait cycles,
// everything else completes one cycle after sampling. Loads read before the same-edge write.
module mem_stage_ext
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int LAT    = 0,
  parameter int TAG_W  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_stage_ext_if.slave bus
);

  localparam int         WA_W    = ADDR_W - 2;
  localparam logic [2:0] LAT_C   = 3'(LAT);
  localparam logic       HAS_LAT = (LAT != 0);

  state_e      state_q;
  logic [2:0]  cnt_q;

  logic [1:0]      lane;
  logic [WA_W-1:0] waddr;
  logic            mem_op, misal, aligned_op, start_wait, done, do_write;
  logic [31:0]     rd_word, ld_data;

  logic              valid_q, wreg_q, m2reg_q, misal_q;
  logic [DATA_W-1:0] mdata_q, alu_q;
  logic [4:0]        dest_q;
  logic [TAG_W-1:0]  type_q, num_q;

  logic              valid_d, wreg_d, m2reg_d, misal_d;
  logic [DATA_W-1:0] mdata_d, alu_d;
  logic [4:0]        dest_d;
  logic [TAG_W-1:0]  type_d, num_d;

  assign lane  = bus.ex_aluR[1:0];
  assign waddr = bus.ex_aluR[ADDR_W-1:2];

  always_comb begin
    mem_op     = bus.ex_valid & (bus.ex_m2reg | bus.ex_wmem);
    misal      = mem_op & misaligned(bus.ex_size, lane);
    aligned_op = mem_op & ~misal;
    start_wait = HAS_LAT & (state_q == IDLE) & aligned_op;
    // In WAIT the count only ever runs 1..LAT, so equality marks the final cycle.
    done       = (state_q == IDLE) ? ~start_wait : (cnt_q == LAT_C);
    do_write   = done & aligned_op & bus.ex_wmem;
  end

  data_mem_be #(.AW(WA_W)) u_mem (
    .clk     (clk),
    .we_i    (do_write),
    .be_i    (lane_en(bus.ex_size, lane)),
    .addr_i  (waddr),
    .wdata_i (store_data(bus.ex_size, bus.ex_inB)),
    .rdata_o (rd_word)
  );

  assign ld_data = load_ext(rd_word, bus.ex_size, lane, bus.ex_unsigned);

  always_comb begin
    valid_d = bus.ex_valid;
    wreg_d  = bus.ex_valid & bus.ex_wreg & ~misal;
    m2reg_d = bus.ex_valid & bus.ex_m2reg;
    misal_d = misal;
    mdata_d = (aligned_op & bus.ex_m2reg) ? ld_data : '0;
    alu_d   = bus.ex_valid ? bus.ex_aluR : '0;
    dest_d  = bus.ex_valid ? bus.ex_destR : '0;
    type_d  = bus.ex_valid ? bus.EXE_ins_type : '0;
    num_d   = bus.ex_valid ? bus.EXE_ins_number : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      misal_q <= 1'b0;
      mdata_q <= '0;
      alu_q   <= '0;
      dest_q  <= '0;
      type_q  <= '0;
      num_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_wait) begin
            state_q <= WAIT;
            cnt_q   <= 3'd1;
          end
        end
        WAIT: begin
          if (done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase

      // Cycles that do not complete the access push a bubble to write-back.
      if (done) begin
        valid_q <= valid_d;
        wreg_q  <= wreg_d;
        m2reg_q <= m2reg_d;
        misal_q <= misal_d;
        mdata_q <= mdata_d;
        alu_q   <= alu_d;
        dest_q  <= dest_d;
        type_q  <= type_d;
        num_q   <= num_d;
      end else begin
        valid_q <= 1'b0;
        wreg_q  <= 1'b0;
        m2reg_q <= 1'b0;
        misal_q <= 1'b0;
        mdata_q <= '0;
        alu_q   <= '0;
        dest_q  <= '0;
        type_q  <= '0;
        num_q   <= '0;
      end
    end
  end

  assign bus.mem_stall      = ~done;
  assign bus.mem_valid      = valid_q;
  assign bus.mem_wreg       = wreg_q;
  assign bus.mem_m2reg      = m2reg_q;
  assign bus.mem_misalign   = misal_q;
  assign bus.mem_mdata      = mdata_q;
  assign bus.mem_aluR       = alu_q;
  assign bus.mem_destR      = dest_q;
  assign bus.MEM_ins_type   = type_q;
  assign bus.MEM_ins_number = num_q;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Drives identical operations into a LAT=0 and a LAT=3 instance and checks both
// against a byte-array reference model.
module tb_mem_stage_ext;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst3_n;
  logic        valid0, valid3;
  logic        wreg, m2reg, wmem, uns;
  logic [1:0]  size;
  logic [4:0]  destR;
  logic [31:0] inB, aluR;
  logic [3:0]  ty, nu;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl [0:255];
  logic        x_misal, x_stall;
  logic [31:0] x_mdata;
  logic [31:0] last_md0, last_md3;

  mem_stage_ext_if #(.DATA_W(32), .TAG_W(4)) if0 ();
  mem_stage_ext_if #(.DATA_W(32), .TAG_W(4)) if3 ();

  assign if0.ex_valid = valid0;        assign if3.ex_valid = valid3;
  assign if0.ex_destR = destR;         assign if3.ex_destR = destR;
  assign if0.ex_inB = inB;             assign if3.ex_inB = inB;
  assign if0.ex_aluR = aluR;           assign if3.ex_aluR = aluR;
  assign if0.ex_wreg = wreg;           assign if3.ex_wreg = wreg;
  assign if0.ex_m2reg = m2reg;         assign if3.ex_m2reg = m2reg;
  assign if0.ex_wmem = wmem;           assign if3.ex_wmem = wmem;
  assign if0.ex_size = size;           assign if3.ex_size = size;
  assign if0.ex_unsigned = uns;        assign if3.ex_unsigned = uns;
  assign if0.EXE_ins_type = ty;        assign if3.EXE_ins_type = ty;
  assign if0.EXE_ins_number = nu;      assign if3.EXE_ins_number = nu;

  mem_stage_ext #(.DATA_W(32), .ADDR_W(8), .LAT(0), .TAG_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(if0.slave));
  mem_stage_ext #(.DATA_W(32), .ADDR_W(8), .LAT(3), .TAG_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(if3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory is a flat byte array, accesses are n consecutive little-endian bytes.
  task automatic model_op();
    int          n;
    logic [7:0]  a;
    logic [31:0] w;
    a = aluR[7:0];
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    x_misal = (m2reg || wmem) && ((int'(a) % n) != 0);
    x_stall = (m2reg || wmem) && !x_misal;
    w = 32'h0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = mdl[(int'(a) + i) % 256];
    if (n == 1 && !uns) w = {{24{w[7]}}, w[7:0]};
    if (n == 2 && !uns) w = {{16{w[15]}}, w[15:0]};
    x_mdata = (m2reg && !x_misal) ? w : 32'h0;
    if (wmem && !x_misal)
      for (int i = 0; i < n; i++) mdl[(int'(a) + i) % 256] = inB[8*i +: 8];
  endtask

  task automatic chk_res(input string who, input logic v, input logic w, input logic m2,
                         input logic mis, input logic [31:0] md, input logic [31:0] al,
                         input logic [4:0] dr, input logic [3:0] t, input logic [3:0] u);
    chk({who, ".valid"}, 32'(v), 32'h1);
    chk({who, ".wreg"}, 32'(w), 32'(wreg & ~x_misal));
    chk({who, ".m2reg"}, 32'(m2), 32'(m2reg));
    chk({who, ".misalign"}, 32'(mis), 32'(x_misal));
    chk({who, ".mdata"}, md, x_mdata);
    chk({who, ".aluR"}, al, aluR);
    chk({who, ".dest_tags"}, {19'h0, dr, t, u}, {19'h0, destR, ty, nu});
  endtask

  task automatic set_op(input logic w_mem, input logic m2r, input logic [1:0] sz,
                        input logic u, input logic [31:0] addr, input logic [31:0] data);
    wmem  = w_mem;
    m2reg = m2r;
    wreg  = m2r;
    size  = sz;
    uns   = u;
    aluR  = addr;
    inB   = data;
    destR = 5'($urandom_range(0, 31));
    ty    = 4'($urandom_range(0, 15));
    nu    = 4'($urandom_range(0, 15));
  endtask

  task automatic do_op();
    int n;
    model_op();
    @(negedge clk);
    valid0 = 1'b1;
    valid3 = 1'b1;
    #1;
    chk("stall0", 32'(if0.mem_stall), 32'h0);
    chk("stall3", 32'(if3.mem_stall), 32'(x_stall));
    @(posedge clk); #1;
    valid0 = 1'b0;
    last_md0 = if0.mem_mdata;
    chk_res("dut0", if0.mem_valid, if0.mem_wreg, if0.mem_m2reg, if0.mem_misalign,
            if0.mem_mdata, if0.mem_aluR, if0.mem_destR, if0.MEM_ins_type, if0.MEM_ins_number);
    if (x_stall) begin
      n = 1;
      while (if3.mem_stall && n < 20) begin
        chk("bubble3", 32'(if3.mem_valid), 32'h0);
        @(posedge clk); #1;
        n++;
      end
      chk("stall_len3", 32'(n), 32'd3);
      chk("bubble3_last", 32'(if3.mem_valid), 32'h0);
      @(posedge clk); #1;
    end
    valid3 = 1'b0;
    last_md3 = if3.mem_mdata;
    chk_res("dut3", if3.mem_valid, if3.mem_wreg, if3.mem_m2reg, if3.mem_misalign,
            if3.mem_mdata, if3.mem_aluR, if3.mem_destR, if3.MEM_ins_type, if3.MEM_ins_number);
    @(posedge clk); #1;
    chk("pulse0", 32'(if0.mem_valid), 32'h0);
    chk("pulse3", 32'(if3.mem_valid), 32'h0);
  endtask

  initial begin
    int kind;
    logic [31:0] addr;
    rst0_n = 1'b0; rst3_n = 1'b0;
    valid0 = 1'b0; valid3 = 1'b0;
    set_op(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst0_ctl", {28'h0, if0.mem_valid, if0.mem_wreg, if0.mem_m2reg, if0.mem_misalign}, 32'h0);
    chk("rst0_data", if0.mem_mdata | if0.mem_aluR, 32'h0);
    chk("rst3_ctl", {27'h0, if3.mem_stall, if3.mem_valid, if3.mem_wreg, if3.mem_m2reg,
                     if3.mem_misalign}, 32'h0);
    chk("rst3_tags", {19'h0, if3.mem_destR, if3.MEM_ins_type, if3.MEM_ins_number}, 32'h0);
    @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1;

    for (int w = 0; w < 64; w++) begin
      set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'(w * 4), $urandom);
      do_op();
    end

    set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF); do_op();
    set_op(1'b0, 1'b1, SZ_B, 1'b0, 32'h13, 32'h0);        do_op();
    chk("tp_lb13_0", last_md0, 32'hFFFFFFDE);
    chk("tp_lb13_3", last_md3, 32'hFFFFFFDE);
    set_op(1'b0, 1'b1, SZ_B, 1'b1, 32'h13, 32'h0);        do_op();
    chk("tp_lbu13", last_md0, 32'h000000DE);
    set_op(1'b0, 1'b1, SZ_H, 1'b0, 32'h10, 32'h0);        do_op();
    chk("tp_lh10", last_md0, 32'hFFFFBEEF);

    set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);        do_op();
    set_op(1'b1, 1'b0, SZ_B, 1'b0, 32'h21, 32'h12345678); do_op();
    set_op(1'b0, 1'b1, SZ_W, 1'b0, 32'h20, 32'h0);        do_op();
    chk("tp_sb21", last_md3, 32'h00007800);

    set_op(1'b1, 1'b0, SZ_H, 1'b0, 32'h11, 32'hAAAA5555); do_op();
    set_op(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'h0);        do_op();
    chk("tp_mis_nowrite", last_md3, 32'hDEADBEEF);

    set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h104, 32'hC0FFEE11); do_op();
    set_op(1'b0, 1'b1, SZ_W, 1'b0, 32'h004, 32'h0);        do_op();
    chk("tp_wrap", last_md0, 32'hC0FFEE11);

    // Store with m2reg returns the pre-store word.
    set_op(1'b1, 1'b1, SZ_W, 1'b0, 32'h40, 32'h55AA55AA); do_op();
    set_op(1'b1, 1'b1, SZ_W, 1'b0, 32'h40, 32'h01020304); do_op();
    chk("tp_rbw", last_md3, 32'h55AA55AA);

    set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h30, 32'h11223344); do_op();
    set_op(1'b1, 1'b0, SZ_W, 1'b0, 32'h30, 32'hCAFEF00D);
    @(negedge clk);
    valid3 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("abort_stall", 32'(if3.mem_stall), 32'h1);
    @(negedge clk);
    valid3 = 1'b0;
    rst3_n = 1'b0;
    #1;
    chk("abort_ctl", {27'h0, if3.mem_stall, if3.mem_valid, if3.mem_wreg, if3.mem_m2reg,
                      if3.mem_misalign}, 32'h0);
    chk("abort_data", if3.mem_mdata | if3.mem_aluR, 32'h0);
    @(negedge clk);
    rst3_n = 1'b1;
    set_op(1'b0, 1'b1, SZ_W, 1'b0, 32'h30, 32'h0); do_op();
    chk("abort_nowrite", last_md3, 32'h11223344);

    for (int k = 0; k < 150; k++) begin
      kind = $urandom_range(0, 3);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      set_op(kind == 1 || kind == 2, kind == 0 || kind == 2, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), addr, $urandom);
      if (kind == 3) wreg = 1'($urandom_range(0, 1));
      do_op();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
